// File: rtl/main_control.sv
// RV32I main control decoder: maps the 7-bit opcode to datapath control signals.
// Latency: 1 cycle (all outputs registered); no backpressure, a new opcode is accepted every cycle.
module main_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  output logic       Branch,
  output logic       MemRead,
  output logic       MemtoReg,
  output logic [1:0] ALUOp,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       Jump,
  output logic       Jalr,
  output logic [1:0] ALUSrcA,
  output logic [2:0] ImmSel,
  output logic       Illegal
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic       jalr;
    logic [1:0] alu_src_a;
    logic [2:0] imm_sel;
    logic       illegal;
  } ctrl_t;

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  always_comb begin
    ctrl_d = '0;
    case (Opcode)
      OP_BRANCH: begin
        ctrl_d.branch  = 1'b1;
        ctrl_d.alu_op  = 2'b01;
        ctrl_d.imm_sel = 3'b010;
      end
      OP_LOAD: begin
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.reg_write  = 1'b1;
      end
      OP_STORE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.imm_sel   = 3'b001;
      end
      OP_ALUI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      OP_RTYPE: begin
        ctrl_d.alu_op    = 2'b10;
        ctrl_d.reg_write = 1'b1;
      end
      OP_JAL: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.jump      = 1'b1;
        ctrl_d.alu_src_a = 2'b01;
        ctrl_d.imm_sel   = 3'b100;
      end
      OP_JALR: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.jump      = 1'b1;
        ctrl_d.jalr      = 1'b1;
      end
      OP_LUI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src_a = 2'b10;
        ctrl_d.imm_sel   = 3'b011;
      end
      OP_AUIPC: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src_a = 2'b01;
        ctrl_d.imm_sel   = 3'b011;
      end
      // Unsupported opcodes flag Illegal with every side-effecting control low.
      default: ctrl_d.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) ctrl_q <= '0;
    else        ctrl_q <= ctrl_d;
  end

  assign Branch   = ctrl_q.branch;
  assign MemRead  = ctrl_q.mem_read;
  assign MemtoReg = ctrl_q.mem_to_reg;
  assign ALUOp    = ctrl_q.alu_op;
  assign MemWrite = ctrl_q.mem_write;
  assign ALUSrc   = ctrl_q.alu_src;
  assign RegWrite = ctrl_q.reg_write;
  assign Jump     = ctrl_q.jump;
  assign Jalr     = ctrl_q.jalr;
  assign ALUSrcA  = ctrl_q.alu_src_a;
  assign ImmSel   = ctrl_q.imm_sel;
  assign Illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_main_control.sv
// Directed bench for main_control: expected control vectors are queued when an opcode is driven
// and compared one edge later; vector order {Branch,MemRead,MemtoReg,ALUOp,MemWrite,ALUSrc,RegWrite,Jump,Jalr,ALUSrcA,ImmSel,Illegal}.
module tb_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Opcode;
  logic       Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Jump, Jalr, Illegal;
  logic [1:0] ALUOp, ALUSrcA;
  logic [2:0] ImmSel;
  logic [15:0] obs;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  localparam logic [15:0] E_ZERO   = 16'b0_0_0_00_0_0_0_0_0_00_000_0;
  localparam logic [15:0] E_BRANCH = 16'b1_0_0_01_0_0_0_0_0_00_010_0;
  localparam logic [15:0] E_LOAD   = 16'b0_1_1_00_0_1_1_0_0_00_000_0;
  localparam logic [15:0] E_STORE  = 16'b0_0_0_00_1_1_0_0_0_00_001_0;
  localparam logic [15:0] E_ALUI   = 16'b0_0_0_00_0_1_1_0_0_00_000_0;
  localparam logic [15:0] E_RTYPE  = 16'b0_0_0_10_0_0_1_0_0_00_000_0;
  localparam logic [15:0] E_JAL    = 16'b0_0_0_00_0_1_1_1_0_01_100_0;
  localparam logic [15:0] E_JALR   = 16'b0_0_0_00_0_1_1_1_1_00_000_0;
  localparam logic [15:0] E_LUI    = 16'b0_0_0_00_0_1_1_0_0_10_011_0;
  localparam logic [15:0] E_AUIPC  = 16'b0_0_0_00_0_1_1_0_0_01_011_0;
  localparam logic [15:0] E_ILL    = 16'b0_0_0_00_0_0_0_0_0_00_000_1;

  always #5 clk = ~clk;

  main_control dut (
    .clk      (clk),
    .reset    (reset),
    .Opcode   (Opcode),
    .Branch   (Branch),
    .MemRead  (MemRead),
    .MemtoReg (MemtoReg),
    .ALUOp    (ALUOp),
    .MemWrite (MemWrite),
    .ALUSrc   (ALUSrc),
    .RegWrite (RegWrite),
    .Jump     (Jump),
    .Jalr     (Jalr),
    .ALUSrcA  (ALUSrcA),
    .ImmSel   (ImmSel),
    .Illegal  (Illegal)
  );

  assign obs = {Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite,
                Jump, Jalr, ALUSrcA, ImmSel, Illegal};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
  endtask

  // Drive one opcode at the falling edge, queue its expected decode, compare just after the next rising edge.
  task automatic apply(input logic rst_n, input logic [6:0] op, input logic [15:0] want, input string tag);
    @(negedge clk);
    reset  = rst_n;
    Opcode = op;
    exp_q.push_back(want);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      string       t;
      logic [15:0] e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, obs, e);
      check({t, "_rdwr_excl"}, {15'b0, MemRead & MemWrite}, 16'h0000);
      check({t, "_jalr_jump"}, {15'b0, Jalr & ~Jump}, 16'h0000);
    end
  endtask

  initial begin
    reset  = 1'b0;
    Opcode = 7'b0110011;

    apply(1'b0, 7'b0110011, E_ZERO,   "reset_rtype");
    apply(1'b0, 7'b1101111, E_ZERO,   "reset_jal");
    apply(1'b1, 7'b0110011, E_RTYPE,  "release_rtype");

    apply(1'b1, 7'b1100011, E_BRANCH, "branch");
    apply(1'b1, 7'b0000011, E_LOAD,   "load");
    apply(1'b1, 7'b0100011, E_STORE,  "store");
    apply(1'b1, 7'b0010011, E_ALUI,   "alu_imm");
    apply(1'b1, 7'b0110011, E_RTYPE,  "rtype");

    apply(1'b1, 7'b1101111, E_JAL,    "jal");
    apply(1'b1, 7'b1100111, E_JALR,   "jalr");
    apply(1'b1, 7'b0110111, E_LUI,    "lui");

    // Opcode wiggles between edges must not reach the registered outputs.
    #2 Opcode = 7'b0000011;
    #1 check("midcycle_hold_a", obs, E_LUI);
    Opcode = 7'b1111111;
    #1 check("midcycle_hold_b", obs, E_LUI);

    apply(1'b1, 7'b0010111, E_AUIPC,  "auipc");

    apply(1'b1, 7'b1111111, E_ILL,    "illegal_ones");
    apply(1'b1, 7'b0000000, E_ILL,    "illegal_zero");
    apply(1'b1, 7'b0110001, E_ILL,    "illegal_low_bits");
    apply(1'b1, 7'b0001111, E_ILL,    "illegal_fence");
    apply(1'b1, 7'b0000011, E_LOAD,   "load_after_illegal");

    apply(1'b1, 7'b0100011, E_STORE,  "store_pre_reset");
    apply(1'b0, 7'b0000011, E_ZERO,   "midseq_reset");
    apply(1'b0, 7'b1111111, E_ZERO,   "reset_masks_illegal");
    apply(1'b1, 7'b1100111, E_JALR,   "release_jalr");
    apply(1'b1, 7'b1100011, E_BRANCH, "branch_final");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
